// File: rtl/booth_div.sv
// rtl/booth_div.sv - sequential signed restoring divider, 2W-bit dividend by W-bit divisor
module booth_div #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               ovf,
  output logic               dz
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  lo_q;
  logic [W-1:0]  dv_q;
  logic [W-1:0]  dd_low_q;
  logic          sq_q;
  logic          sr_q;
  logic          dz_pend_q;
  logic          pre_ovf_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          ovf_q;
  logic          dz_q;
  logic [W-1:0]  quotient_q;
  logic [W-1:0]  remainder_q;

  logic [2*W-1:0] dd_abs_d;
  logic [W-1:0]   dv_abs_d;
  logic [W:0]     trial_d;
  logic           ge_d;
  logic [W-1:0]   diff_d;
  logic [W-1:0]   quot_fix_d;
  logic [W-1:0]   rem_fix_d;
  logic           q_range_d;

  always_comb begin
    dd_abs_d   = dividend[2*W-1] ? -dividend : dividend;
    dv_abs_d   = divisor[W-1] ? -divisor : divisor;
    trial_d    = {rem_q, lo_q[W-1]};
    ge_d       = trial_d >= {1'b0, dv_q};
    // Partial remainder stays below |dv|, so the low W bits hold the exact difference.
    diff_d     = trial_d[W-1:0] - dv_q;
    quot_fix_d = sq_q ? -lo_q : lo_q;
    rem_fix_d  = sr_q ? -rem_q : rem_q;
    q_range_d  = sq_q ? (lo_q > HALF) : lo_q[W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      lo_q        <= '0;
      dv_q        <= '0;
      dd_low_q    <= '0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      dz_pend_q   <= 1'b0;
      pre_ovf_q   <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_q     <= dd_abs_d[2*W-1:W];
            lo_q      <= dd_abs_d[W-1:0];
            dv_q      <= dv_abs_d;
            dd_low_q  <= dividend[W-1:0];
            sq_q      <= dividend[2*W-1] ^ divisor[W-1];
            sr_q      <= dividend[2*W-1];
            dz_pend_q <= (divisor == '0);
            pre_ovf_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= CALC;
          end
        end
        CALC: begin
          // First CALC cycle registers the range precheck off the latched magnitudes.
          if (cnt_q == '0) begin
            pre_ovf_q <= !dz_pend_q && (rem_q >= dv_q);
          end else begin
            rem_q <= ge_d ? diff_d : trial_d[W-1:0];
            lo_q  <= {lo_q[W-2:0], ge_d};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W)) state_q <= FIX;
        end
        FIX: begin
          quotient_q  <= dz_pend_q ? '1 : quot_fix_d;
          remainder_q <= dz_pend_q ? dd_low_q : rem_fix_d;
          ovf_q       <= !dz_pend_q && (pre_ovf_q || q_range_d);
          dz_q        <= dz_pend_q;
          done_q      <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_booth_div.sv
// tb/tb_booth_div.sv - self-checking bench for booth_div against an integer-arithmetic model
module tb_booth_div;

  localparam int W = 4;
  localparam int LAT = W + 2;
  localparam int PERIOD = W + 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           ovf;
  logic           dz;

  int checks = 0;
  int errors = 0;

  booth_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Truncating division on plain integers; overflow means the quotient leaves W-bit signed range.
  function automatic void ref_div(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic o, output logic z);
    int a;
    int b;
    int qi;
    int ri;
    a = $signed(dd);
    b = $signed(dv);
    z = (b == 0);
    if (z) begin
      q = '1;
      r = dd[W-1:0];
      o = 1'b0;
    end else begin
      qi = a / b;
      ri = a % b;
      o = (qi > (2**(W-1)) - 1) || (qi < -(2**(W-1)));
      q = qi[W-1:0];
      r = ri[W-1:0];
    end
  endfunction

  task automatic check_res(input string tag, input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic o;
    logic z;
    ref_div(dd, dv, q, r, o, z);
    chk({tag, "_dz"}, dz, z);
    chk({tag, "_ovf"}, ovf, o);
    if (!o) begin
      chk({tag, "_q"}, quotient, q);
      chk({tag, "_r"}, remainder, r);
    end
  endtask

  task automatic run_op(input string tag, input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    int n;
    @(negedge clk);
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    chk({tag, "_busy_acc"}, busy, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 4 * LAT) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_busy_done"}, busy, 1'b1);
    check_res(tag, dd, dv);
    @(posedge clk);
    #1;
    chk({tag, "_done_fall"}, done, 1'b0);
    chk({tag, "_busy_fall"}, busy, 1'b0);
  endtask

  logic [2*W-1:0] hdd [0:63];
  logic [W-1:0]   hdv [0:63];
  logic [11:0]    idx;
  int             seen_done;
  int             off;
  int             stride;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", quotient, 4'h0);
    chk("rst_r", remainder, 4'h0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_dz", dz, 1'b0);
    rst = 1'b0;

    run_op("t1", 8'sd24, 4'b1100);
    chk("t1_q_const", quotient, 4'b1010);
    chk("t1_r_const", remainder, 4'h0);
    run_op("t2a", 8'sd32, 4'b1100);
    chk("t2a_q_const", quotient, 4'b1000);
    chk("t2a_ovf_const", ovf, 1'b0);
    run_op("t2b", 8'sd32, 4'd4);
    chk("t2b_ovf_const", ovf, 1'b1);
    run_op("t3a", -8'sd7, 4'd2);
    chk("t3a_q_const", quotient, 4'b1101);
    chk("t3a_r_const", remainder, 4'b1111);
    run_op("t3b", 8'sd7, 4'b1110);
    chk("t3b_q_const", quotient, 4'b1101);
    chk("t3b_r_const", remainder, 4'b0001);
    run_op("t4", 8'h35, 4'h0);
    chk("t4_dz_const", dz, 1'b1);
    chk("t4_q_const", quotient, 4'hF);
    chk("t4_r_const", remainder, 4'h5);
    run_op("min_dd", 8'h80, 4'b1000);
    run_op("min_dv", 8'sd40, 4'b1000);
    run_op("t1_again", 8'sd24, 4'b1100);

    // Abort in the middle of CALC.
    @(negedge clk);
    start = 1'b1;
    dividend = 8'sd24;
    divisor = 4'b1100;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_q", quotient, 4'h0);
    chk("abort_r", remainder, 4'h0);
    chk("abort_ovf", ovf, 1'b0);
    seen_done = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen_done++;
    end
    chk("abort_no_done", seen_done, 0);
    run_op("after_abort", 8'hE9, 4'd5);

    // start held high with operands changing every cycle.
    for (int i = 0; i < 6 * PERIOD; i++) begin
      @(negedge clk);
      start = 1'b1;
      dividend = $urandom;
      divisor = $urandom;
      hdd[i] = dividend;
      hdv[i] = divisor;
      @(posedge clk);
      #1;
      chk("hold_done", done, (i % PERIOD) == LAT);
      if ((i % PERIOD) == LAT) check_res("hold", hdd[i - LAT], hdv[i - LAT]);
    end
    start = 1'b0;

    // Every operand pair once, in a random order.
    off = $urandom_range(0, 4095);
    stride = 2 * $urandom_range(0, 2047) + 1;
    for (int i = 0; i < 4096; i++) begin
      idx = 12'((i * stride + off) & 12'hFFF);
      run_op("sweep", idx[11:4], idx[3:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
